// File: rtl/cache_ctrl_if.sv
// CPU, cache-array, data-memory and flush signals of the cache sequencer.
// slave: the controller side; master: the CPU/array/memory environment side.
interface cache_ctrl_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              busy;
  logic [1:0]        ca_idx;
  logic [1:0]        ca_off;
  logic              ca_we;
  logic [DATA_W-1:0] ca_wdata;
  logic [DATA_W-1:0] ca_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              flush_req;
  logic              flush_done;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ca_rdata, mem_rdata, mem_ack, flush_req,
    output cpu_rdata, cpu_ready, busy, ca_idx, ca_off, ca_we, ca_wdata,
           mem_req, mem_we, mem_addr, mem_wdata, flush_done
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ca_rdata, mem_rdata, mem_ack, flush_req,
    input  cpu_rdata, cpu_ready, busy, ca_idx, ca_off, ca_we, ca_wdata,
           mem_req, mem_we, mem_addr, mem_wdata, flush_done
  );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back cache sequencer (4 lines x 4 words): hit service, writeback, refill.
// Define CACHE_FLUSH_EN to build the FLUSH state that writes back every dirty line.
module cache_ctrl #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input logic         clock,
  input logic         reset_n,
  cache_ctrl_if.slave bus
);
  localparam int unsigned TAG_W = ADDR_W - 4;
  localparam int unsigned LINES = 4;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_WRITEBACK = 3'd2;
  localparam logic [2:0] S_REFILL    = 3'd3;
`ifdef CACHE_FLUSH_EN
  localparam logic [2:0] S_FLUSH     = 3'd4;
`endif

  logic [2:0]                  r_state, w_state_nxt;
  logic [1:0]                  r_cnt, w_cnt_nxt;
  logic                        r_we;
  logic [ADDR_W-1:0]           r_addr;
  logic [DATA_W-1:0]           r_wdata;
  logic                        r_cpu_ready, w_cpu_ready_nxt;
  logic [DATA_W-1:0]           r_cpu_rdata, w_cpu_rdata_nxt;
  logic [LINES-1:0]            r_valid, r_dirty;
  logic [LINES-1:0][TAG_W-1:0] r_tag;

  logic              w_latch, w_set_dirty, w_clr_dirty, w_fill, w_hit;
  logic [1:0]        w_idx;
  logic [TAG_W-1:0]  w_tag_req;
  logic [1:0]        w_ca_off;
  logic              w_ca_we;
  logic [DATA_W-1:0] w_ca_wdata;
  logic              w_mem_req, w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

`ifdef CACHE_FLUSH_EN
  logic       r_flushing, w_flushing_nxt;
  logic [1:0] r_fidx, w_fidx_nxt;
  logic       r_flush_done, w_flush_done_nxt;
  assign w_idx = r_flushing ? r_fidx : r_addr[3:2];
`else
  logic w_unused_flush;
  assign w_unused_flush = bus.flush_req;
  assign w_idx          = r_addr[3:2];
`endif

  assign w_tag_req = r_addr[ADDR_W-1:4];
  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag_req);

  // Next-state and combinational array/memory controls
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_cpu_ready_nxt = 1'b0;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_latch         = 1'b0;
    w_set_dirty     = 1'b0;
    w_clr_dirty     = 1'b0;
    w_fill          = 1'b0;
    w_ca_off        = r_addr[1:0];
    w_ca_we         = 1'b0;
    w_ca_wdata      = r_wdata;
    w_mem_req       = 1'b0;
    w_mem_we        = 1'b0;
    w_mem_addr      = '0;
    w_mem_wdata     = '0;
`ifdef CACHE_FLUSH_EN
    w_flushing_nxt   = r_flushing;
    w_fidx_nxt       = r_fidx;
    w_flush_done_nxt = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
`ifdef CACHE_FLUSH_EN
        if (bus.flush_req) begin
          w_state_nxt    = S_FLUSH;
          w_flushing_nxt = 1'b1;
          w_fidx_nxt     = 2'd0;
        end else if (bus.cpu_req) begin
          w_latch     = 1'b1;
          w_state_nxt = S_LOOKUP;
        end
`else
        if (bus.cpu_req) begin
          w_latch     = 1'b1;
          w_state_nxt = S_LOOKUP;
        end
`endif
      end
      S_LOOKUP: begin
        if (w_hit) begin
          w_cpu_ready_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
          if (r_we) begin
            w_ca_we     = 1'b1;
            w_set_dirty = 1'b1;
          end else begin
            w_cpu_rdata_nxt = bus.ca_rdata;
          end
        end else begin
          w_cnt_nxt   = 2'd0;
          w_state_nxt = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_REFILL;
        end
      end
      S_WRITEBACK: begin
        w_ca_off    = r_cnt;
        w_mem_req   = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = {r_tag[w_idx], w_idx, r_cnt};
        w_mem_wdata = bus.ca_rdata;
        if (bus.mem_ack) begin
          w_cnt_nxt = r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
`ifdef CACHE_FLUSH_EN
            if (r_flushing) begin
              w_clr_dirty = 1'b1;
              w_state_nxt = S_FLUSH;
            end else begin
              w_state_nxt = S_REFILL;
            end
`else
            w_state_nxt = S_REFILL;
`endif
          end
        end
      end
      S_REFILL: begin
        w_ca_off   = r_cnt;
        w_mem_req  = 1'b1;
        w_mem_addr = {w_tag_req, w_idx, r_cnt};
        if (bus.mem_ack) begin
          w_ca_we    = 1'b1;
          w_ca_wdata = bus.mem_rdata;
          w_cnt_nxt  = r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            w_fill      = 1'b1;
            w_state_nxt = S_LOOKUP;
          end
        end
      end
`ifdef CACHE_FLUSH_EN
      // A written-back line comes back here clean, so the walk then advances
      S_FLUSH: begin
        if (r_valid[r_fidx] && r_dirty[r_fidx]) begin
          w_cnt_nxt   = 2'd0;
          w_state_nxt = S_WRITEBACK;
        end else if (r_fidx == 2'd3) begin
          w_flush_done_nxt = 1'b1;
          w_flushing_nxt   = 1'b0;
          w_state_nxt      = S_IDLE;
        end else begin
          w_fidx_nxt = r_fidx + 2'd1;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Request latch, word counter, CPU response and line bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_ready <= 1'b0;
      r_cpu_rdata <= '0;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_tag       <= '0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_cpu_ready <= w_cpu_ready_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      if (w_latch) begin
        r_we    <= bus.cpu_we;
        r_addr  <= bus.cpu_addr;
        r_wdata <= bus.cpu_wdata;
      end
      if (w_set_dirty) r_dirty[w_idx] <= 1'b1;
      if (w_clr_dirty) r_dirty[w_idx] <= 1'b0;
      if (w_fill) begin
        r_tag[w_idx]   <= w_tag_req;
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
    end
  end

`ifdef CACHE_FLUSH_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_flushing   <= 1'b0;
      r_fidx       <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_flushing   <= w_flushing_nxt;
      r_fidx       <= w_fidx_nxt;
      r_flush_done <= w_flush_done_nxt;
    end
  end
  assign bus.flush_done = r_flush_done;
`else
  assign bus.flush_done = 1'b0;
`endif

  assign bus.cpu_ready = r_cpu_ready;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.ca_idx    = w_idx;
  assign bus.ca_off    = w_ca_off;
  assign bus.ca_we     = w_ca_we;
  assign bus.ca_wdata  = w_ca_wdata;
  assign bus.mem_req   = w_mem_req;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
endmodule
